// File: rtl/nic_port_sched.sv
// Scheduler sharing one NIC register port between four TX requesters and one RX consumer.
// Define NIC_SCHED_RR_EN for round-robin TX arbitration; otherwise fixed priority (requester 0 highest).
module nic_port_sched #(
    parameter int PAC_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             tx_req,
    input  logic [4*PAC_WIDTH-1:0] tx_data,
    output logic [3:0]             tx_gnt,
    input  logic                   rx_ready,
    output logic                   rx_valid,
    output logic [PAC_WIDTH-1:0]   rx_data,
    output logic [1:0]             nic_addr,
    output logic [PAC_WIDTH-1:0]   nic_d_in,
    input  logic [PAC_WIDTH-1:0]   nic_d_out,
    output logic                   nicEn,
    output logic                   nicWrEn
);
    typedef enum logic [2:0] {IDLE, CHK_OUT, WR_OUT, CHK_IN, RD_IN} state_t;
    localparam logic TURN_TX = 1'b0;
    localparam logic TURN_RX = 1'b1;

    state_t               state_q, state_d;
    logic                 turn_q;
    logic [1:0]           pick;
    logic                 pick_vld;
    logic [3:0]           gnt_q;
    logic                 rx_valid_q;
    logic [PAC_WIDTH-1:0] rx_data_q;
    logic [PAC_WIDTH-1:0] nic_d_in_q;
    logic [1:0]           nic_addr_q;
    logic                 nic_en_q;
    logic                 nic_wr_q;
    logic                 flag;
    logic [PAC_WIDTH-1:0] slice [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_slice
        assign slice[gi] = tx_data[gi*PAC_WIDTH +: PAC_WIDTH];
    end

    assign flag = nic_d_out[PAC_WIDTH-1];

`ifdef NIC_SCHED_RR_EN
    logic [1:0] ptr_q;
    logic [1:0] winner_q;

    // Descending scan so the requester closest to the pointer is assigned last and wins.
    always_comb begin
        pick     = ptr_q;
        pick_vld = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (tx_req[ptr_q + 2'(k)]) begin
                pick     = ptr_q + 2'(k);
                pick_vld = 1'b1;
            end
        end
    end
`else
    always_comb begin
        pick     = 2'd0;
        pick_vld = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (tx_req[k]) begin
                pick     = 2'(k);
                pick_vld = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (turn_q == TURN_TX && |tx_req) state_d = CHK_OUT;
                else if (rx_ready)                state_d = CHK_IN;
                else if (|tx_req)                 state_d = CHK_OUT;
            end
            CHK_OUT: state_d = (flag || !pick_vld) ? IDLE : WR_OUT;
            WR_OUT:  state_d = IDLE;
            CHK_IN:  state_d = flag ? RD_IN : IDLE;
            RD_IN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they are valid throughout each state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            turn_q     <= TURN_TX;
            gnt_q      <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            nic_d_in_q <= '0;
            nic_addr_q <= 2'b00;
            nic_en_q   <= 1'b0;
            nic_wr_q   <= 1'b0;
`ifdef NIC_SCHED_RR_EN
            ptr_q      <= 2'd0;
            winner_q   <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= '0;
            rx_valid_q <= 1'b0;
            nic_d_in_q <= '0;
            nic_en_q   <= (state_d != IDLE);
            nic_wr_q   <= (state_d == WR_OUT);
            case (state_d)
                CHK_OUT: nic_addr_q <= 2'b11;
                WR_OUT:  nic_addr_q <= 2'b10;
                CHK_IN:  nic_addr_q <= 2'b01;
                default: nic_addr_q <= 2'b00;
            endcase
            case (state_q)
                CHK_OUT: begin
                    if (state_d == WR_OUT) begin
                        gnt_q      <= 4'b0001 << pick;
                        nic_d_in_q <= slice[pick];
`ifdef NIC_SCHED_RR_EN
                        winner_q   <= pick;
`endif
                    end else begin
                        turn_q <= TURN_RX;
                    end
                end
                WR_OUT: begin
                    turn_q <= TURN_RX;
`ifdef NIC_SCHED_RR_EN
                    ptr_q  <= winner_q + 2'd1;
`endif
                end
                CHK_IN: begin
                    if (!flag) turn_q <= TURN_TX;
                end
                RD_IN: begin
                    rx_data_q  <= nic_d_out;
                    rx_valid_q <= 1'b1;
                    turn_q     <= TURN_TX;
                end
                default: ;
            endcase
        end
    end

    // Reset abandons an in-flight write: the grant and the NIC enable are suppressed in that cycle.
    assign tx_gnt   = gnt_q & {4{~reset}};
    assign nicEn    = nic_en_q & ~reset;
    assign nicWrEn  = nic_wr_q;
    assign nic_addr = nic_addr_q;
    assign nic_d_in = nic_d_in_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
endmodule

// File: tb/tb_nic_port_sched.sv
// Scoreboard bench for nic_port_sched: NIC model, directed scenarios, then randomized traffic.
`timescale 1ns/1ps
module tb_nic_port_sched;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [3:0]     tx_req = 4'b0;
    logic [4*W-1:0] tx_data = '0;
    logic [3:0]     tx_gnt;
    logic           rx_ready = 1'b0;
    logic           rx_valid;
    logic [W-1:0]   rx_data;
    logic [1:0]     nic_addr;
    logic [W-1:0]   nic_d_in;
    logic [W-1:0]   nic_d_out;
    logic           nicEn;
    logic           nicWrEn;

    logic           out_full = 1'b0;
    logic           in_full = 1'b0;
    logic [W-1:0]   in_pkt = '0;
    logic [W-1:0]   junk = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_tx = 0;
    int n_rx = 0;
    int last_w = 3;
    int rd_cyc = -1;

    typedef struct {
        int           cyc;
        logic [3:0]   gnt;
        logic [W-1:0] data;
    } exp_t;
    exp_t exp_tx[$];
    exp_t exp_rx[$];

    nic_port_sched #(.PAC_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .tx_req(tx_req), .tx_data(tx_data), .tx_gnt(tx_gnt),
        .rx_ready(rx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .nic_addr(nic_addr),
        .nic_d_in(nic_d_in), .nic_d_out(nic_d_out), .nicEn(nicEn), .nicWrEn(nicWrEn)
    );

    always #5 clk = ~clk;

    // NIC register file: status words carry the full flag in the MSB, low bits are noise.
    always_comb begin
        case (nic_addr)
            2'b11:   nic_d_out = {out_full, junk[W-2:0]};
            2'b01:   nic_d_out = {in_full, junk[W-2:0]};
            2'b00:   nic_d_out = in_pkt;
            default: nic_d_out = junk;
        endcase
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_pick(input logic [3:0] req);
`ifdef NIC_SCHED_RR_EN
        for (int k = 1; k <= 4; k++) if (req[(last_w + k) % 4]) return (last_w + k) % 4;
`else
        for (int k = 0; k < 4; k++) if (req[k]) return k;
`endif
        return 0;
    endfunction

    // Monitor: predicts transactions from the NIC's answers and checks what the DUT presents.
    initial forever begin
        exp_t e;
        int   w;
        logic rd;
        @(negedge clk);
        cyc++;
        if (reset) begin
            exp_tx.delete();
            exp_rx.delete();
            last_w = 3;
            rd_cyc = -1;
        end else begin
            if (nicEn && !nicWrEn && nic_addr == 2'b11 && !out_full && tx_req != 4'b0) begin
                w      = model_pick(tx_req);
                e.cyc  = cyc + 1;
                e.gnt  = 4'b0001 << w;
                e.data = tx_data[w*W +: W];
                exp_tx.push_back(e);
                last_w = w;
            end
            if (nicEn && !nicWrEn && nic_addr == 2'b01) rd_cyc = in_full ? cyc + 1 : -1;
            rd = nicEn && !nicWrEn && nic_addr == 2'b00;
            if (rd || rd_cyc == cyc) chk("read_timing", rd, (rd_cyc == cyc));
            if (rd) begin
                e.cyc  = cyc + 1;
                e.gnt  = 4'b0;
                e.data = in_pkt;
                exp_rx.push_back(e);
            end
            if (tx_gnt != 4'b0 || (exp_tx.size() > 0 && exp_tx[0].cyc == cyc)) begin
                if (exp_tx.size() == 0) begin
                    chk("gnt_unexpected", tx_gnt, 4'b0);
                end else begin
                    e = exp_tx.pop_front();
                    n_tx++;
                    $display("TX cycle=%0d gnt=%b data=%h", cyc, tx_gnt, nic_d_in);
                    chk("gnt_value", tx_gnt, e.gnt);
                    chk("gnt_cycle", cyc, e.cyc);
                    chk("wr_data", nic_d_in, e.data);
                    chk("wr_ctrl", {nicEn, nicWrEn, nic_addr}, 4'b1110);
                end
            end
            if (nicEn && nicWrEn) chk("write_has_gnt", |tx_gnt, 1'b1);
            if (rx_valid || (exp_rx.size() > 0 && exp_rx[0].cyc == cyc)) begin
                if (exp_rx.size() == 0) begin
                    chk("rx_valid_unexpected", rx_valid, 1'b0);
                end else begin
                    e = exp_rx.pop_front();
                    n_rx++;
                    $display("RX cycle=%0d data=%h", cyc, rx_data);
                    chk("rx_valid", rx_valid, 1'b1);
                    chk("rx_data", rx_data, e.data);
                end
            end
        end
    end

    task automatic wait_access(input logic [1:0] a, input logic wr, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(nicEn && nicWrEn == wr && nic_addr == a) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_seen"}, (n < 50), 1'b1);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d0;
        logic [W-1:0] d2;
        logic [1:0]   seq[$];
        logic [1:0]   pat[4];
        logic [3:0]   got32[$];
        logic [3:0]   exp32[5];
        logic [3:0]   g;
        int n, nchk, bad, nst, run, max_run;

        pat = '{2'b11, 2'b10, 2'b01, 2'b00};
`ifdef NIC_SCHED_RR_EN
        exp32 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        exp32 = '{default: 4'b0001};
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_gnt", tx_gnt, 4'b0);
        chk("rst_ctrl", {nicEn, nicWrEn, nic_addr}, 4'b0);
        chk("rst_rx", {rx_valid, rx_data}, '0);
        chk("rst_d_in", nic_d_in, '0);

        // Single request, output buffer empty: grant two cycles later
        next();
        reset = 1'b0;
        d0 = {$urandom, $urandom};
        tx_data[0 +: W] = d0;
        tx_req = 4'b0001;
        @(negedge clk);
        chk("t31_c0_idle", {nicEn, tx_gnt}, 5'b0);
        next();
        @(negedge clk);
        chk("t31_c1_chk", {nicEn, nicWrEn, nic_addr, tx_gnt}, 8'b1011_0000);
        next();
        @(negedge clk);
        chk("t31_c2_wr", {nicEn, nicWrEn, nic_addr, tx_gnt}, 8'b1110_0001);
        chk("t31_c2_data", nic_d_in, d0);
        next();
        tx_req = 4'b0;
        @(negedge clk);
        chk("t31_c3_idle", {nicEn, tx_gnt}, 5'b0);

        // Output buffer full for three checks, then clears
        next();
        d2 = {$urandom, $urandom};
        tx_data[2*W +: W] = d2;
        tx_req = 4'b0100;
        out_full = 1'b1;
        n = 0; nchk = 0; bad = 0;
        while (nchk < 3 && n < 40) begin
            @(negedge clk);
            n++;
            if (nicEn && !nicWrEn && nic_addr == 2'b11) nchk++;
            if (tx_gnt != 4'b0 || (nicEn && nicWrEn)) bad++;
        end
        chk("t33_checks_while_full", nchk, 3);
        chk("t33_no_write_while_full", bad, 0);
        next();
        out_full = 1'b0;
        wait_access(2'b10, 1'b1, "t33_wr");
        chk("t33_gnt", tx_gnt, 4'b0100);
        chk("t33_data", nic_d_in, d2);
        next();
        tx_req = 4'b0;

        // Receive one packet
        rx_ready = 1'b1;
        in_full = 1'b1;
        in_pkt = 64'hDEAD_BEEF_0000_0001;
        wait_access(2'b00, 1'b0, "t34_rd");
        next();
        in_full = 1'b0;
        rx_ready = 1'b0;
        @(negedge clk);
        chk("t34_rx_valid", rx_valid, 1'b1);
        chk("t34_rx_data", rx_data, 64'hDEAD_BEEF_0000_0001);
        next();
        @(negedge clk);
        chk("t34_rx_pulse_end", rx_valid, 1'b0);
        chk("t34_rx_data_held", rx_data, 64'hDEAD_BEEF_0000_0001);

        // Input buffer empty: status polled, never read
        next();
        rx_ready = 1'b1;
        n = 0; nst = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if ((nicEn && !nicWrEn && nic_addr == 2'b00) || rx_valid) n++;
            if (nicEn && nic_addr == 2'b01) nst++;
        end
        chk("t26_no_read_empty", n, 0);
        chk("t26_status_polled", (nst > 0), 1'b1);
        next();
        rx_ready = 1'b0;
        repeat (3) next();

        // TX and RX both ready: accesses alternate
        tx_req = 4'b0001;
        rx_ready = 1'b1;
        in_full = 1'b1;
        in_pkt = {$urandom, $urandom};
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (nicEn) seq.push_back(nic_addr);
        end
        chk("t35_seq_len", (seq.size() >= 8), 1'b1);
        for (int k = 0; k < 8 && k < seq.size(); k++) chk("t35_seq", seq[k], pat[k % 4]);
        next();
        tx_req = 4'b0;
        rx_ready = 1'b0;
        in_full = 1'b0;
        repeat (4) next();

        // All four requesting continuously after reset
        reset = 1'b1;
        next();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tx_data[i*W +: W] = {$urandom, $urandom};
        tx_req = 4'b1111;
        n = 0;
        while (got32.size() < 5 && n < 60) begin
            @(negedge clk);
            n++;
            if (tx_gnt != 4'b0) got32.push_back(tx_gnt);
        end
        chk("t32_count", got32.size(), 5);
        for (int k = 0; k < 5 && k < got32.size(); k++) chk("t32_gnt", got32[k], exp32[k]);
        next();
        tx_req = 4'b0;
        repeat (4) next();

        // Reset during the write cycle
        tx_data[0 +: W] = {$urandom, $urandom};
        tx_req = 4'b0001;
        wait_access(2'b11, 1'b0, "t36_chk");
        next();
        reset = 1'b1;
        @(negedge clk);
        chk("t36_gnt_masked", tx_gnt, 4'b0);
        next();
        reset = 1'b0;
        rx_ready = 1'b1;
        @(negedge clk);
        chk("t36_post_rst_ctrl", {tx_gnt, rx_valid, nicEn, nicWrEn, nic_addr}, 9'b0);
        chk("t36_post_rst_rx_data", rx_data, '0);
        chk("t36_post_rst_d_in", nic_d_in, '0);
        next();
        @(negedge clk);
        chk("t36_turn_tx_first", {nicEn, nic_addr}, 3'b111);
        wait_access(2'b10, 1'b1, "t36_wr");
        next();
        tx_req = 4'b0;
        rx_ready = 1'b0;
        repeat (4) next();

        // Randomized traffic
        run = 0; max_run = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            g = tx_gnt;
            if (tx_req != 4'b0 && g == 4'b0) run++;
            else run = 0;
            if (run > max_run) max_run = run;
            next();
            tx_req = tx_req & ~g;
            for (int i = 0; i < 4; i++) begin
                if (!tx_req[i] && $urandom_range(3) == 0) begin
                    tx_data[i*W +: W] = {$urandom, $urandom};
                    tx_req[i] = 1'b1;
                end
            end
            rx_ready = 1'($urandom_range(1));
            out_full = ($urandom_range(3) == 0);
            in_full  = 1'($urandom_range(1));
            in_pkt   = {$urandom, $urandom};
            junk     = {$urandom, $urandom};
        end
        rx_ready = 1'b0;
        out_full = 1'b0;
        in_full = 1'b0;
        n = 0;
        while (tx_req != 4'b0 && n < 100) begin
            @(negedge clk);
            g = tx_gnt;
            next();
            tx_req = tx_req & ~g;
            n++;
        end
        repeat (5) next();
        chk("rand_max_stall", (max_run <= 100), 1'b1);
        chk("drain_done", tx_req, 4'b0);
        chk("exp_tx_empty", exp_tx.size(), 0);
        chk("exp_rx_empty", exp_rx.size(), 0);
        chk("tx_activity", (n_tx > 100), 1'b1);
        chk("rx_activity", (n_rx > 50), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
